// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point pipelined multiplier.
package fxp_pkg;

   // Rounding-mode encodings carried alongside each operand pair.
   localparam logic [1:0] RND_TRUNC     = 2'b00;
   localparam logic [1:0] RND_HALF_UP   = 2'b01;
   localparam logic [1:0] RND_HALF_EVEN = 2'b10;

   // Largest representable signed value for a given result width.
   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // True two's-complement minimum for a given result width.
   function automatic logic signed [63:0] sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/fxp_booth_pp.sv
// Radix-4 Booth digit encoder and one unshifted partial-product row.
module fxp_booth_pp #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [2:0]         trip,
   output logic [2*WIDTH-1:0] row
);

   logic [2*WIDTH-1:0] ax;

   assign ax = {{WIDTH{a[WIDTH-1]}}, a};

   // Select 0, +-a or +-2a from the overlapping multiplier bit triplet.
   always_comb begin
      // NOTE: every path assigns row, so no latch is inferred.
      row = '0;
      case (trip)
         3'b001, 3'b010: row = ax;
         3'b011:         row = ax << 1;
         3'b100:         row = -(ax << 1);
         3'b101, 3'b110: row = -ax;
         default:        row = '0;
      endcase
   end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Parametrised signed fixed-point multiplier: Booth rows, carry-save tree,
// final add with selectable rounding and saturation, valid/ready pipeline.
module fxp_mult_pipe
   import fxp_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int FRAC  = 22,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       rnd_mode,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p,
   output logic             sat,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] sat_cnt,
   input  logic             clr_cnt
);

   localparam int ROWS = (WIDTH + 1) / 2;
   localparam int PW   = 2 * WIDTH;
   localparam int XW   = PW + 1;
   localparam int BXW  = 2 * ROWS + 1;

   localparam logic signed [XW-1:0] MAX_X    = XW'(sat_max(WIDTH));
   localparam logic signed [XW-1:0] MIN_X    = XW'(sat_min(WIDTH));
   localparam logic        [XW-1:0] HALF_LSB = XW'(1) << (FRAC - 1);

   // Global advance: the whole pipe moves together or holds together.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage 1 state
   logic             v1;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       mode1;
   logic [TAG_W-1:0] tag1;

   // Stage 2 state
   logic             v2;
   logic [1:0]       mode2;
   logic [TAG_W-1:0] tag2;
   logic [PW-1:0]    pp_row [ROWS];
   logic [PW-1:0]    pp_q   [ROWS];

   // Stage 3 state
   logic             v3;
   logic [1:0]       mode3;
   logic [TAG_W-1:0] tag3;
   logic [PW-1:0]    cs_sum, cs_carry;
   logic [PW-1:0]    sum_q, carry_q;

   // Multiplier with a 0 appended below the LSB and sign-extended on top.
   logic signed [BXW-1:0] bx;
   assign bx = BXW'($signed({b_q, 1'b0}));

   // Capture operands and sideband on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: registers update with <= so every stage samples pre-edge values.
         v1    <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         mode1 <= RND_TRUNC;
         tag1  <= '0;
      end else if (adv) begin
         v1    <= in_valid;
         a_q   <= a;
         b_q   <= b;
         mode1 <= rnd_mode;
         tag1  <= tag;
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_booth
      fxp_booth_pp #(.WIDTH(WIDTH)) u_pp (
         .a    (a_q),
         .trip (bx[2*i+2 -: 3]),
         .row  (pp_row[i])
      );
   end

   // Register the weighted partial-product rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         mode2 <= RND_TRUNC;
         tag2  <= '0;
         // NOTE: the row array is small flops, not RAM, so clearing it is cheap and keeps p defined.
         for (int i = 0; i < ROWS; i++) pp_q[i] <= '0;
      end else if (adv) begin
         v2    <= v1;
         mode2 <= mode1;
         tag2  <= tag1;
         for (int i = 0; i < ROWS; i++) pp_q[i] <= pp_row[i] << (2 * i);
      end
   end

   // Linear 3:2 carry-save chain folding all rows into sum and carry.
   always_comb begin : csa_tree
      logic [PW-1:0] s, c, r, t;
      s = pp_q[0];
      c = pp_q[1];
      r = '0;
      t = '0;
      for (int i = 2; i < ROWS; i++) begin
         r = pp_q[i];
         t = s ^ c ^ r;
         c = ((s & c) | (s & r) | (c & r)) << 1;
         s = t;
      end
      cs_sum   = s;
      cs_carry = c;
   end

   // Register the redundant product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3      <= 1'b0;
         mode3   <= RND_TRUNC;
         tag3    <= '0;
         sum_q   <= '0;
         carry_q <= '0;
      end else if (adv) begin
         v3      <= v2;
         mode3   <= mode2;
         tag3    <= tag2;
         sum_q   <= cs_sum;
         carry_q <= cs_carry;
      end
   end

   // Final add, rounding at bit FRAC and clamp to the result range.
   logic [PW-1:0]         prod;
   logic [XW-1:0]         prod_x, rnd_add;
   logic signed [XW-1:0]  sum_x, rounded;
   logic                  sat_hi, sat_lo;
   logic [WIDTH-1:0]      p_next;

   always_comb begin
      prod    = sum_q + carry_q;
      prod_x  = {prod[PW-1], prod};
      rnd_add = '0;
      case (mode3)
         RND_HALF_UP:   rnd_add = HALF_LSB;
         RND_HALF_EVEN: rnd_add = HALF_LSB - XW'(1) + XW'(prod[FRAC]);
         default:       rnd_add = '0;
      endcase
      sum_x   = prod_x + rnd_add;
      rounded = sum_x >>> FRAC;
      sat_hi  = rounded > MAX_X;
      sat_lo  = rounded < MIN_X;
      if (sat_hi)      p_next = MAX_X[WIDTH-1:0];
      else if (sat_lo) p_next = MIN_X[WIDTH-1:0];
      else             p_next = rounded[WIDTH-1:0];
   end

   // Output register; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         p         <= '0;
         sat       <= 1'b0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= v3;
         p         <= p_next;
         sat       <= sat_hi || sat_lo;
         out_tag   <= tag3;
      end
   end

   // Count saturated results delivered downstream; clear wins, sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt <= '0;
      end else if (clr_cnt) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && sat && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe (WIDTH=24, FRAC=22): table of vectors with
// a scoreboard monitor, plus sequences for stall, reset and counter edges.
module tb_fxp_mult_pipe;

   localparam int W  = 24;
   localparam int TW = 4;
   localparam int CW = 16;

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, sat, clr_cnt;
   logic [W-1:0]  a, b, p;
   logic [1:0]    rnd_mode;
   logic [TW-1:0] tag, out_tag;
   logic [CW-1:0] sat_cnt;

   fxp_mult_pipe #(.WIDTH(W), .FRAC(22), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .rnd_mode  (rnd_mode),
      .tag       (tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .sat       (sat),
      .out_tag   (out_tag),
      .sat_cnt   (sat_cnt),
      .clr_cnt   (clr_cnt)
   );

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [1:0]  mode;
      logic [3:0]  tag;
      logic [23:0] p;
      logic        s;
   } vec_t;

   typedef struct {
      logic [23:0] p;
      logic        s;
      logic [3:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   vec_t vt [17];
   exp_t sb [$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   model_cnt = 0;
   bit   lat_chk = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp_v);
      end
   endtask

   // Scoreboard: every delivered result must match the oldest accepted operation.
   always @(negedge clk) begin
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", out_valid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("p", p, e.p);
            check("sat", sat, e.s);
            check("out_tag", out_tag, e.tag);
            if (e.lat) check("latency", cyc - e.acc, 4);
            if (e.s && model_cnt < 65535) model_cnt++;
         end
      end
   end

   task automatic send(input vec_t v, input logic [3:0] t);
      bit   done;
      exp_t e;
      done = 0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a        = v.a;
         b        = v.b;
         rnd_mode = v.mode;
         tag      = t;
         #1;
         if (in_ready) begin
            done  = 1;
            e.p   = v.p;
            e.s   = v.s;
            e.tag = t;
            e.acc = cyc;
            e.lat = lat_chk;
            sb.push_back(e);
         end
      end
      if (!done) check("accept_timeout", in_ready, 1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && sb.size() != 0; k++) begin
         @(negedge clk);
         #3;
      end
      check("drain", sb.size(), 0);
      @(negedge clk);
      #1;
   endtask

   initial begin
      // a, b, mode, tag, expected p, expected sat
      vt[0]  = '{24'h400000, 24'h400000, 2'd0, 4'd5,  24'h400000, 1'b0};
      vt[1]  = '{24'hC00000, 24'h400000, 2'd0, 4'd6,  24'hC00000, 1'b0};
      vt[2]  = '{24'h800000, 24'h800000, 2'd0, 4'd7,  24'h7FFFFF, 1'b1};
      vt[3]  = '{24'h800000, 24'h400000, 2'd0, 4'd8,  24'h800000, 1'b0};
      vt[4]  = '{24'h000001, 24'h200000, 2'd0, 4'd9,  24'h000000, 1'b0};
      vt[5]  = '{24'h000001, 24'h200000, 2'd1, 4'd10, 24'h000001, 1'b0};
      vt[6]  = '{24'h000001, 24'h200000, 2'd2, 4'd11, 24'h000000, 1'b0};
      vt[7]  = '{24'h000003, 24'h200000, 2'd0, 4'd12, 24'h000001, 1'b0};
      vt[8]  = '{24'h000003, 24'h200000, 2'd1, 4'd13, 24'h000002, 1'b0};
      vt[9]  = '{24'h000003, 24'h200000, 2'd2, 4'd14, 24'h000002, 1'b0};
      vt[10] = '{24'hFFFFFF, 24'h200000, 2'd0, 4'd15, 24'hFFFFFF, 1'b0};
      vt[11] = '{24'hFFFFFF, 24'h200000, 2'd1, 4'd0,  24'h000000, 1'b0};
      vt[12] = '{24'hFFFFFF, 24'h200000, 2'd2, 4'd1,  24'h000000, 1'b0};
      vt[13] = '{24'hFFFFFD, 24'h200000, 2'd1, 4'd2,  24'hFFFFFF, 1'b0};
      vt[14] = '{24'h7FFFFF, 24'h7FFFFF, 2'd2, 4'd3,  24'h7FFFFF, 1'b1};
      vt[15] = '{24'h000003, 24'h200000, 2'd3, 4'd4,  24'h000001, 1'b0};
      vt[16] = '{24'h800000, 24'h7FFFFF, 2'd1, 4'd5,  24'h800000, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      rnd_mode  = 2'd0;
      tag       = '0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_p", p, 0);
      check("rst_sat", sat, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      // Back-to-back table vectors, unstalled, with latency tracked per result.
      lat_chk = 1;
      for (int i = 0; i < 17; i++) send(vt[i], vt[i].tag);
      idle();
      drain();
      check("tbl_sat_cnt", sat_cnt, model_cnt);

      // Stall the output for 5 cycles once the first of 6 results is valid.
      lat_chk = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(vt[i], 4'(i + 1));
            idle();
         end
         begin : stall_thr
            logic [23:0] p0;
            bit          seen;
            seen = 0;
            for (int k = 0; k < 30 && !seen; k++) begin
               @(negedge clk);
               if (out_valid) seen = 1;
            end
            check("bp_first_valid", out_valid, 1);
            out_ready = 1'b0;
            p0 = p;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_p_stable", p, p0);
               check("bp_in_ready", in_ready, 0);
               check("bp_valid_hold", out_valid, 1);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_sat_cnt", sat_cnt, model_cnt);

      // Reset with a full, stalled pipe.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(vt[2], 4'(i));
      idle();
      #1;
      check("rst2_pre_valid", out_valid, 1);
      check("rst2_pre_cnt", sat_cnt, model_cnt);
      rst_n = 1'b0;
      #1;
      check("rst2_out_valid", out_valid, 0);
      check("rst2_sat_cnt", sat_cnt, 0);
      check("rst2_p", p, 0);
      check("rst2_in_ready", in_ready, 1);
      sb.delete();
      model_cnt = 0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      begin
         int n;
         n = 0;
         repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
         end
         check("rst2_no_stale", n, 0);
      end

      // Clear in the same cycle as a saturating handshake.
      lat_chk = 1;
      send(vt[2], 4'd1);
      send(vt[2], 4'd2);
      idle();
      drain();
      check("clr_pre_cnt", sat_cnt, 2);
      send(vt[2], 4'd3);
      idle();
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      check("clr_wait_valid", out_valid, 1);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      #1;
      check("clr_priority", sat_cnt, 0);
      model_cnt = 0;
      send(vt[2], 4'd4);
      idle();
      drain();
      check("clr_post_cnt", sat_cnt, 1);

      // Drive the counter past all-ones; it must stick.
      for (int i = 0; i < 65537; i++) send(vt[2], 4'(i));
      idle();
      drain();
      check("cnt_stick", sat_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
